// File: rtl/mc_controller.sv
// Multi-cycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB); MC_ILLEGAL_TRAP_EN enables the HALT trap on unknown encodings.
// Latency 2..4+MEM_LAT cycles per instruction; no backpressure, outputs are combinational from state, op, funct and zero.
module mc_controller #(
    parameter int MEM_LAT = 1,
    parameter int ALUOP_W = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         op,
    input  logic [5:0]         funct,
    input  logic               zero,
    output logic               PCWr,
    output logic               IRWr,
    output logic [1:0]         NPCSel,
    output logic               RegWrite,
    output logic [1:0]         RegDst,
    output logic [1:0]         MemtoReg,
    output logic               MemWrite,
    output logic               ALUSrc,
    output logic               ExtOp,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic [2:0]         state,
    output logic               instr_done,
    output logic               illegal
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_LUI  = 6'b001111;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_JR   = 6'b001000;

    localparam logic [3:0]         CNT_LAST = 4'(MEM_LAT - 1);
    localparam logic [ALUOP_W-1:0] ALU_ADD  = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] ALU_SUB  = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] ALU_OR   = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] ALU_LUI  = ALUOP_W'(3);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    logic is_r, is_addu, is_subu, is_jr, is_lw, is_sw, is_beq, is_lui, is_ori, is_jal, is_legal;
    logic pc_wr, ir_wr, reg_wr, mem_wr, alu_en;
    logic alu_src, ext_op;
    logic [ALUOP_W-1:0] alu_op;

    assign is_r     = (op == OP_R);
    assign is_addu  = is_r && (funct == FN_ADDU);
    assign is_subu  = is_r && (funct == FN_SUBU);
    assign is_jr    = is_r && (funct == FN_JR);
    assign is_lw    = (op == OP_LW);
    assign is_sw    = (op == OP_SW);
    assign is_beq   = (op == OP_BEQ);
    assign is_lui   = (op == OP_LUI);
    assign is_ori   = (op == OP_ORI);
    assign is_jal   = (op == OP_JAL);
    assign is_legal = is_addu | is_subu | is_jr | is_lw | is_sw | is_beq | is_lui | is_ori | is_jal;

    // ALU controls depend only on the instruction, so EXEC/MEM/WB all present the same values
    always_comb begin
        alu_src = is_lw | is_sw | is_ori | is_lui;
        ext_op  = is_lw | is_sw | is_beq;
        alu_op  = ALU_ADD;
        if (is_subu || is_beq) alu_op = ALU_SUB;
        else if (is_ori)       alu_op = ALU_OR;
        else if (is_lui)       alu_op = ALU_LUI;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef MC_ILLEGAL_TRAP_EN
    logic halt;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pc_wr      = 1'b0;
        ir_wr      = 1'b0;
        reg_wr     = 1'b0;
        mem_wr     = 1'b0;
        alu_en     = 1'b0;
        NPCSel     = 2'd0;
        RegDst     = 2'd0;
        MemtoReg   = 2'd0;
        instr_done = 1'b0;
`ifdef MC_ILLEGAL_TRAP_EN
        halt       = 1'b0;
`endif
        case (state_q)
            S_FETCH: begin
                pc_wr   = 1'b1;
                ir_wr   = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (is_jal) begin
                    pc_wr      = 1'b1;
                    NPCSel     = 2'd2;
                    reg_wr     = 1'b1;
                    RegDst     = 2'd2;
                    MemtoReg   = 2'd2;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end else if (is_jr) begin
                    pc_wr      = 1'b1;
                    NPCSel     = 2'd3;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end else if (is_legal) begin
                    state_d = S_EXEC;
                end else begin
`ifdef MC_ILLEGAL_TRAP_EN
                    state_d = S_HALT;
`else
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
`endif
                end
            end
            S_EXEC: begin
                alu_en = 1'b1;
                if (is_beq) begin
                    pc_wr      = zero;
                    NPCSel     = 2'd1;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end else if (is_lw || is_sw) begin
                    cnt_d   = 4'd0;
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                alu_en = 1'b1;
                if (cnt_q != 4'hF) cnt_d = cnt_q + 4'd1;
                if (cnt_q == CNT_LAST) begin
                    if (is_lw) begin
                        state_d = S_WB;
                    end else begin
                        mem_wr     = is_sw;
                        instr_done = 1'b1;
                        state_d    = S_FETCH;
                    end
                end
            end
            S_WB: begin
                alu_en     = 1'b1;
                reg_wr     = 1'b1;
                RegDst     = is_r  ? 2'd1 : 2'd0;
                MemtoReg   = is_lw ? 2'd1 : 2'd0;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_HALT: begin
`ifdef MC_ILLEGAL_TRAP_EN
                halt    = 1'b1;
                state_d = S_HALT;
`else
                state_d = S_FETCH;
`endif
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Write enables are masked while reset is high so an abandoned instruction leaves no trace
    assign PCWr     = pc_wr  & ~reset;
    assign IRWr     = ir_wr  & ~reset;
    assign RegWrite = reg_wr & ~reset;
    assign MemWrite = mem_wr & ~reset;
    assign ALUSrc   = alu_en & alu_src;
    assign ExtOp    = alu_en & ext_op;
    assign ALUOp    = alu_en ? alu_op : ALU_ADD;
    assign state    = state_q;

`ifdef MC_ILLEGAL_TRAP_EN
    assign illegal = halt & ~reset;
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller (MEM_LAT = 3); compares a packed snapshot of every output each cycle.
module tb_mc_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] op = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       zero = 1'b0;
    logic       PCWr, IRWr, RegWrite, MemWrite, ALUSrc, ExtOp, instr_done, illegal;
    logic [1:0] NPCSel, RegDst, MemtoReg;
    logic [2:0] ALUOp, state;
    logic [19:0] obs;
    int checks = 0;
    int errors = 0;

    mc_controller #(.MEM_LAT(3), .ALUOP_W(3)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .PCWr(PCWr), .IRWr(IRWr), .NPCSel(NPCSel), .RegWrite(RegWrite),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .MemWrite(MemWrite),
        .ALUSrc(ALUSrc), .ExtOp(ExtOp), .ALUOp(ALUOp), .state(state),
        .instr_done(instr_done), .illegal(illegal)
    );

    always #5 clk = ~clk;

    assign obs = {state, PCWr, IRWr, NPCSel, RegWrite, RegDst, MemtoReg,
                  MemWrite, ALUSrc, ExtOp, ALUOp, instr_done, illegal};

    function automatic logic [19:0] ev(input int st, pcwr, irwr, npc, rw, rd, m2r,
                                       mw, as_, eo, aop, done, ill);
        return {3'(st), 1'(pcwr), 1'(irwr), 2'(npc), 1'(rw), 2'(rd), 2'(m2r),
                1'(mw), 1'(as_), 1'(eo), 3'(aop), 1'(done), 1'(ill)};
    endfunction

    function automatic logic [19:0] fetch_v();
        return ev(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks++;
        if (obs !== ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)) begin
            errors++;
            $display("FAIL reset_hold obs=%h exp=%h", obs, ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        end
        reset = 1'b0;
        #1;
        checks++;
        if (obs !== fetch_v()) begin
            errors++;
            $display("FAIL reset_release obs=%h exp=%h", obs, fetch_v());
        end
    endtask

    task automatic test_itype();
        logic [19:0] e [2][5];
        logic [5:0]  ops [2];
        ops[0] = 6'b001101;
        ops[1] = 6'b001111;
        e[0][0] = fetch_v();
        e[0][1] = ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        e[0][2] = ev(2, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2, 0, 0);
        e[0][3] = ev(4, 0, 0, 0, 1, 0, 0, 0, 1, 0, 2, 1, 0);
        e[0][4] = fetch_v();
        e[1][0] = fetch_v();
        e[1][1] = ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        e[1][2] = ev(2, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3, 0, 0);
        e[1][3] = ev(4, 0, 0, 0, 1, 0, 0, 0, 1, 0, 3, 1, 0);
        e[1][4] = fetch_v();
        for (int k = 0; k < 2; k++) begin
            op = ops[k]; funct = 6'd0; zero = 1'b0;
            #1;
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (obs !== e[k][i]) begin
                    errors++;
                    $display("FAIL itype op=%b cyc%0d obs=%h exp=%h", ops[k], i, obs, e[k][i]);
                end
                if (i < 4) step();
            end
        end
    endtask

    task automatic test_rtype();
        logic [19:0] e [2][5];
        logic [5:0]  fns [2];
        fns[0] = 6'b100001;
        fns[1] = 6'b100011;
        e[0][0] = fetch_v();
        e[0][1] = ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        e[0][2] = ev(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        e[0][3] = ev(4, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 0);
        e[0][4] = fetch_v();
        e[1][0] = fetch_v();
        e[1][1] = ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        e[1][2] = ev(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        e[1][3] = ev(4, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 1, 0);
        e[1][4] = fetch_v();
        for (int k = 0; k < 2; k++) begin
            op = 6'd0; funct = fns[k]; zero = 1'b1;
            #1;
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (obs !== e[k][i]) begin
                    errors++;
                    $display("FAIL rtype funct=%b cyc%0d obs=%h exp=%h", fns[k], i, obs, e[k][i]);
                end
                if (i < 4) step();
            end
        end
    endtask

    task automatic test_lw();
        logic [19:0] e [8];
        e[0] = fetch_v();
        e[1] = ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        e[2] = ev(2, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        e[3] = ev(3, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        e[4] = e[3];
        e[5] = e[3];
        e[6] = ev(4, 0, 0, 0, 1, 0, 1, 0, 1, 1, 0, 1, 0);
        e[7] = fetch_v();
        op = 6'b100011; funct = 6'd0; zero = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (obs !== e[i]) begin
                errors++;
                $display("FAIL lw cyc%0d obs=%h exp=%h", i, obs, e[i]);
            end
            if (i < 7) step();
        end
    endtask

    task automatic test_sw();
        logic [19:0] e [7];
        e[0] = fetch_v();
        e[1] = ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        e[2] = ev(2, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        e[3] = ev(3, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        e[4] = e[3];
        e[5] = ev(3, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 1, 0);
        e[6] = fetch_v();
        op = 6'b101011; funct = 6'd0; zero = 1'b0;
        #1;
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (obs !== e[i]) begin
                errors++;
                $display("FAIL sw cyc%0d obs=%h exp=%h", i, obs, e[i]);
            end
            if (i < 6) step();
        end
    endtask

    task automatic test_beq();
        logic [19:0] e [2][4];
        for (int k = 0; k < 2; k++) begin
            e[k][0] = fetch_v();
            e[k][1] = ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            e[k][2] = ev(2, 1 - k, 0, 1, 0, 0, 0, 0, 0, 1, 1, 1, 0);
            e[k][3] = fetch_v();
        end
        for (int k = 0; k < 2; k++) begin
            op = 6'b000100; funct = 6'd0; zero = (k == 0);
            #1;
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (obs !== e[k][i]) begin
                    errors++;
                    $display("FAIL beq zero=%0d cyc%0d obs=%h exp=%h", zero, i, obs, e[k][i]);
                end
                if (i < 3) step();
            end
        end
    endtask

    task automatic test_jump();
        logic [19:0] e [2][3];
        logic [5:0]  ops [2];
        logic [5:0]  fns [2];
        ops[0] = 6'b000011; fns[0] = 6'd0;
        ops[1] = 6'b000000; fns[1] = 6'b001000;
        e[0][0] = fetch_v();
        e[0][1] = ev(1, 1, 0, 2, 1, 2, 2, 0, 0, 0, 0, 1, 0);
        e[0][2] = fetch_v();
        e[1][0] = fetch_v();
        e[1][1] = ev(1, 1, 0, 3, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        e[1][2] = fetch_v();
        for (int k = 0; k < 2; k++) begin
            op = ops[k]; funct = fns[k]; zero = 1'b0;
            #1;
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (obs !== e[k][i]) begin
                    errors++;
                    $display("FAIL jump op=%b cyc%0d obs=%h exp=%h", ops[k], i, obs, e[k][i]);
                end
                if (i < 2) step();
            end
        end
    endtask

    task automatic test_reset_mid_sw();
        logic [19:0] e [5];
        e[0] = fetch_v();
        e[1] = ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        e[2] = ev(2, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        e[3] = ev(3, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        e[4] = e[3];
        op = 6'b101011; funct = 6'd0; zero = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (obs !== e[i]) begin
                errors++;
                $display("FAIL sw_abort cyc%0d obs=%h exp=%h", i, obs, e[i]);
            end
            if (i < 4) step();
        end
        reset = 1'b1;
        #1;
        checks++;
        if (MemWrite !== 1'b0) begin
            errors++;
            $display("FAIL sw_abort_memwrite obs=%b exp=0", MemWrite);
        end
        step();
        checks++;
        if (obs !== ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)) begin
            errors++;
            $display("FAIL sw_abort_reset obs=%h exp=%h", obs, ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        end
        reset = 1'b0;
        #1;
        checks++;
        if (obs !== fetch_v()) begin
            errors++;
            $display("FAIL sw_abort_fetch obs=%h exp=%h", obs, fetch_v());
        end
    endtask

    task automatic test_illegal();
`ifdef MC_ILLEGAL_TRAP_EN
        op = 6'b111111; funct = 6'd0; zero = 1'b0;
        #1;
        checks++;
        if (obs !== fetch_v()) begin
            errors++;
            $display("FAIL trap_fetch obs=%h exp=%h", obs, fetch_v());
        end
        step();
        checks++;
        if (obs !== ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)) begin
            errors++;
            $display("FAIL trap_decode obs=%h exp=%h", obs, ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        end
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (obs !== ev(5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1)) begin
                errors++;
                $display("FAIL trap_halt cyc%0d obs=%h exp=%h", i, obs, ev(5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
            end
        end
        reset = 1'b1;
        #1;
        checks++;
        if (illegal !== 1'b0) begin
            errors++;
            $display("FAIL trap_reset_illegal obs=%b exp=0", illegal);
        end
        step();
        reset = 1'b0;
        #1;
        checks++;
        if (obs !== fetch_v()) begin
            errors++;
            $display("FAIL trap_cleared obs=%h exp=%h", obs, fetch_v());
        end
`else
        logic [5:0] ops [2];
        logic [5:0] fns [2];
        logic [19:0] e [3];
        ops[0] = 6'b111111; fns[0] = 6'd0;
        ops[1] = 6'b000000; fns[1] = 6'b000000;
        e[0] = fetch_v();
        e[1] = ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        e[2] = fetch_v();
        for (int k = 0; k < 2; k++) begin
            op = ops[k]; funct = fns[k]; zero = 1'b0;
            #1;
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (obs !== e[i]) begin
                    errors++;
                    $display("FAIL unknown op=%b funct=%b cyc%0d obs=%h exp=%h", ops[k], fns[k], i, obs, e[i]);
                end
                if (i < 2) step();
            end
        end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation did not complete");
    end

    initial begin
        test_reset();
        test_itype();
        test_rtype();
        test_lw();
        test_sw();
        test_beq();
        test_jump();
        test_reset_mid_sw();
        test_illegal();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
